// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and AXI constants for the sram-like to AXI3 bridge.
// Holds FSM state encodings, fixed burst fields, default IDs and the size mapping.
package cpu_axi_bridge_pkg;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_AR   = 2'd1,
      RD_R    = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_REQ  = 2'd1,
      WR_B    = 2'd2
   } wr_state_t;

   localparam logic [3:0] LEN0        = 4'd0;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [3:0] INST_ID_DEF = 4'd0;
   localparam logic [3:0] DATA_ID_DEF = 4'd1;

   // sram-like size codes (0/1/2) map directly onto AXI log2 byte counts
   function automatic logic [2:0] size_to_axi(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage

// File: rtl/axi_wr_engine.sv
// Single-beat AXI3 write engine: latches one data write, drives AW and W
// independently, then waits for B and pulses done for one cycle.
module axi_wr_engine
   import cpu_axi_bridge_pkg::*;
#(
   parameter logic [3:0] ID = DATA_ID_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic [3:0]  strb,
   input  logic [31:0] data,
   output logic        idle,
   output logic        done,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready,
   output wr_state_t   wr_state
);

   wr_state_t   state_q, state_nxt;
   logic [31:0] addr_q, data_q;
   logic [1:0]  size_q;
   logic [3:0]  strb_q;
   logic        aw_pend, w_pend, done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WR_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= '0;
         strb_q  <= '0;
         aw_pend <= 1'b0;
         w_pend  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         done_q  <= 1'b0;
         case (state_q)
            WR_IDLE: if (start) begin
               addr_q  <= addr;
               data_q  <= data;
               size_q  <= size;
               strb_q  <= strb;
               aw_pend <= 1'b1;
               w_pend  <= 1'b1;
            end
            WR_REQ: begin
               // AW and W complete independently; each valid drops after its own handshake
               if (awready) aw_pend <= 1'b0;
               if (wready)  w_pend  <= 1'b0;
            end
            WR_B: if (bvalid) done_q <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state_q;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      case (state_q)
         WR_IDLE: if (start) state_nxt = WR_REQ;
         WR_REQ: begin
            awvalid = aw_pend;
            wvalid  = w_pend;
            if ((!aw_pend || awready) && (!w_pend || wready)) state_nxt = WR_B;
         end
         WR_B: begin
            bready = 1'b1;
            if (bvalid) state_nxt = WR_IDLE;
         end
         default: state_nxt = WR_IDLE;
      endcase
   end

   assign idle     = (state_q == WR_IDLE);
   assign done     = done_q;
   assign awid     = ID;
   assign awaddr   = addr_q;
   assign awsize   = size_to_axi(size_q);
   assign wdata    = data_q;
   assign wstrb    = strb_q;
   assign wr_state = state_q;

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's inst/data sram-like ports onto one AXI3 master.
// The read FSM lives here; data writes run in a separate engine alongside it.
module cpu_axi_bridge
   import cpu_axi_bridge_pkg::*;
#(
   parameter logic [3:0] INST_ID = INST_ID_DEF,
   parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   output logic [3:0]  arlen,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  awlen,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready,
   output rd_state_t   rd_state,
   output wr_state_t   wr_state
);

   rd_state_t   rd_state_q, rd_state_nxt;
   logic [31:0] rd_addr_q, inst_rdata_q, data_rdata_q;
   logic [1:0]  rd_size_q;
   logic [3:0]  rd_id_q;
   logic        rd_owner_q;
   logic        inst_ok_q, data_rd_ok_q;
   logic        wr_idle, wr_done;
   logic        rd_idle, data_rd_acc, data_wr_acc, inst_acc;
   logic        rid_unused;

   // Data reads wait for the write engine to drain so read-after-write stays ordered
   assign rd_idle     = (rd_state_q == RD_IDLE);
   assign data_rd_acc = data_req && !data_wr && rd_idle && wr_idle;
   assign data_wr_acc = data_req && data_wr && wr_idle && !(!rd_idle && rd_owner_q);
   assign inst_acc    = inst_req && rd_idle && !data_rd_acc && !data_wr_acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state_q   <= RD_IDLE;
         rd_addr_q    <= '0;
         rd_size_q    <= '0;
         rd_id_q      <= '0;
         rd_owner_q   <= 1'b0;
         inst_ok_q    <= 1'b0;
         data_rd_ok_q <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         rd_state_q   <= rd_state_nxt;
         inst_ok_q    <= 1'b0;
         data_rd_ok_q <= 1'b0;
         if (data_rd_acc) begin
            rd_addr_q  <= data_addr;
            rd_size_q  <= data_size;
            rd_id_q    <= DATA_ID;
            rd_owner_q <= 1'b1;
         end else if (inst_acc) begin
            rd_addr_q  <= inst_addr;
            rd_size_q  <= inst_size;
            rd_id_q    <= INST_ID;
            rd_owner_q <= 1'b0;
         end
         if (rd_state_q == RD_R && rvalid) begin
            if (rd_owner_q) begin
               data_rdata_q <= rdata;
               data_rd_ok_q <= 1'b1;
            end else begin
               inst_rdata_q <= rdata;
               inst_ok_q    <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_state_nxt = rd_state_q;
      arvalid      = 1'b0;
      rready       = 1'b0;
      case (rd_state_q)
         RD_IDLE: if (data_rd_acc || inst_acc) rd_state_nxt = RD_AR;
         RD_AR: begin
            arvalid = 1'b1;
            if (arready) rd_state_nxt = RD_R;
         end
         RD_R: begin
            rready = 1'b1;
            if (rvalid) rd_state_nxt = RD_IDLE;
         end
         default: rd_state_nxt = RD_IDLE;
      endcase
   end

   axi_wr_engine #(.ID(DATA_ID)) u_wr (
      .clk      (clk),
      .rst      (rst),
      .start    (data_wr_acc),
      .addr     (data_addr),
      .size     (data_size),
      .strb     (data_wstrb),
      .data     (data_wdata),
      .idle     (wr_idle),
      .done     (wr_done),
      .awid     (awid),
      .awaddr   (awaddr),
      .awsize   (awsize),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wvalid   (wvalid),
      .wready   (wready),
      .bvalid   (bvalid),
      .bready   (bready),
      .wr_state (wr_state)
   );

   // Ownership comes from the latched owner flag, so rid carries no information here
   assign rid_unused   = ^rid;

   assign inst_addr_ok = inst_acc;
   assign data_addr_ok = data_rd_acc || data_wr_acc;
   assign inst_data_ok = inst_ok_q;
   assign data_data_ok = data_rd_ok_q || wr_done;
   assign inst_rdata   = inst_rdata_q;
   assign data_rdata   = data_rdata_q;
   assign arid         = rd_id_q;
   assign araddr       = rd_addr_q;
   assign arsize       = size_to_axi(rd_size_q);
   assign rd_state     = rd_state_q;
   assign arlen        = LEN0;
   assign awlen        = LEN0;
   assign arburst      = BURST_INCR;
   assign awburst      = BURST_INCR;
   assign arlock       = 2'b00;
   assign awlock       = 2'b00;
   assign arcache      = 4'b0000;
   assign awcache      = 4'b0000;
   assign arprot       = 3'b000;
   assign awprot       = 3'b000;
   assign wlast        = 1'b1;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Randomized bench for cpu_axi_bridge: a core-side request generator, an AXI slave
// with random stalls, and a transaction-level model of what each port should see.
module tb_cpu_axi_bridge;
   import cpu_axi_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wstrb;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, arlock, awburst, awlock;
   logic        arvalid, arready, rvalid, rready, awvalid, awready;
   logic        wlast, wvalid, wready, bvalid, bready;
   rd_state_t   rd_state;
   wr_state_t   wr_state;

   cpu_axi_bridge dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .arlen(arlen), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .awlen(awlen), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready), .rd_state(rd_state), .wr_state(wr_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_data_q[$];
   bit          exp_data_rd_q[$];
   logic [31:0] model_mem[logic [31:0]];
   logic [31:0] slave_mem[logic [31:0]];

   int          rd_phase;      // 0 none, 1 waiting on AR, 2 waiting on R
   bit          rd_owner;      // 1 = data port
   int          r_delay, b_delay;
   logic [31:0] r_word, ar_addr_e, aw_addr_e, w_data_e;
   logic [2:0]  ar_size_e, aw_size_e;
   logic [3:0]  ar_id_e, w_strb_e;
   bit          wr_busy, aw_done, w_done;
   bit          inst_req_on, inst_out, data_req_on, data_out;
   bit          exp_i_dok, exp_d_dok;
   logic [31:0] last_inst_rdata, last_data_rdata;
   bit          zero_wait, gen_en, did_reset, first_lat_done;
   int          cyc, first_acc_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] k = {a[31:2], 2'b00};
      return model_mem.exists(k) ? model_mem[k] : dflt(k);
   endfunction

   function automatic logic [31:0] slave_read(input logic [31:0] a);
      logic [31:0] k = {a[31:2], 2'b00};
      return slave_mem.exists(k) ? slave_mem[k] : dflt(k);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_inputs();
      int unsigned sz, idx, off;
      if (gen_en && !inst_req_on && !inst_out && $urandom_range(0, 2) == 0) begin
         inst_req_on = 1'b1;
         inst_addr   = 32'hBFC0_0000 + (32'($urandom_range(0, 63)) << 2);
         inst_size   = 2'd2;
      end
      inst_req = inst_req_on;
      if (gen_en && !data_req_on && !data_out && $urandom_range(0, 2) == 0) begin
         data_req_on = 1'b1;
         data_wr     = 1'($urandom_range(0, 1));
         sz          = $urandom_range(0, 2);
         idx         = $urandom_range(0, 7);
         off         = (sz == 2) ? 0 : (sz == 1) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
         data_size   = 2'(sz);
         data_addr   = 32'h8000_0000 + 32'(idx * 4 + off);
         data_wstrb  = 4'($urandom_range(1, 15));
         data_wdata  = $urandom;
      end
      data_req = data_req_on;
      arready  = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
      awready  = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
      wready   = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
      if (rd_phase == 2 && r_delay == 0) begin
         rvalid = 1'b1;
         rdata  = r_word;
         rid    = ar_id_e;
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
         rid    = 4'($urandom_range(0, 15));
      end
      bvalid = wr_busy && aw_done && w_done && (b_delay == 0);
   endtask

   task automatic check_cycle();
      bit          e_d, e_i, kind;
      logic [31:0] v;
      e_d = data_req && (data_wr ? (!wr_busy && !(rd_phase != 0 && rd_owner))
                                 : (rd_phase == 0 && !wr_busy));
      e_i = inst_req && (rd_phase == 0) && !e_d;
      check("data_addr_ok", data_addr_ok, e_d);
      check("inst_addr_ok", inst_addr_ok, e_i);
      check("arvalid", arvalid, rd_phase == 1);
      check("rready", rready, rd_phase == 2);
      check("awvalid", awvalid, wr_busy && !aw_done);
      check("wvalid", wvalid, wr_busy && !w_done);
      check("bready", bready, wr_busy && aw_done && w_done);
      check("inst_data_ok", inst_data_ok, exp_i_dok);
      check("data_data_ok", data_data_ok, exp_d_dok);

      if (inst_data_ok) begin
         check("inst_q_size", exp_inst_q.size(), 1);
         if (exp_inst_q.size() > 0) last_inst_rdata = exp_inst_q.pop_front();
         inst_out = 1'b0;
         if (first_acc_cyc >= 0 && !first_lat_done) begin
            check("first_latency", cyc - first_acc_cyc, 3);
            first_lat_done = 1'b1;
         end
      end
      check("inst_rdata", inst_rdata, last_inst_rdata);
      if (data_data_ok) begin
         check("data_q_size", exp_data_q.size(), 1);
         if (exp_data_q.size() > 0) begin
            v    = exp_data_q.pop_front();
            kind = exp_data_rd_q.pop_front();
            if (kind) last_data_rdata = v;
         end
         data_out = 1'b0;
      end
      check("data_rdata", data_rdata, last_data_rdata);
      exp_i_dok = 1'b0;
      exp_d_dok = 1'b0;

      // slave read side
      if (rd_phase == 2) begin
         if (rvalid && rready) begin
            rd_phase = 0;
            if (rd_owner) exp_d_dok = 1'b1;
            else          exp_i_dok = 1'b1;
         end else if (r_delay > 0) r_delay--;
      end else if (rd_phase == 1 && arvalid && arready) begin
         check("araddr", araddr, ar_addr_e);
         check("arsize", arsize, ar_size_e);
         check("arid", arid, ar_id_e);
         rd_phase = 2;
         r_word   = slave_read(araddr);
         r_delay  = zero_wait ? 0 : $urandom_range(0, 3);
      end

      // slave write side
      if (wr_busy && aw_done && w_done) begin
         if (bvalid && bready) begin
            wr_busy   = 1'b0;
            exp_d_dok = 1'b1;
         end else if (b_delay > 0) b_delay--;
      end else if (wr_busy) begin
         if (!aw_done && awvalid && awready) begin
            check("awaddr", awaddr, aw_addr_e);
            check("awsize", awsize, aw_size_e);
            check("awid", awid, 4'd1);
            aw_done = 1'b1;
         end
         if (!w_done && wvalid && wready) begin
            check("wdata", wdata, w_data_e);
            check("wstrb", wstrb, w_strb_e);
            check("wlast", wlast, 1'b1);
            w_done = 1'b1;
         end
         if (aw_done && w_done) begin
            slave_mem[{aw_addr_e[31:2], 2'b00}] = merge(slave_read(aw_addr_e), w_data_e, w_strb_e);
            b_delay = zero_wait ? 0 : $urandom_range(0, 3);
         end
      end

      // reference model: the core's view of each accepted request
      if (inst_addr_ok) begin
         inst_req_on = 1'b0;
         inst_out    = 1'b1;
         rd_phase    = 1;
         rd_owner    = 1'b0;
         ar_addr_e   = inst_addr;
         ar_size_e   = {1'b0, inst_size};
         ar_id_e     = 4'd0;
         exp_inst_q.push_back(model_read(inst_addr));
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (data_addr_ok) begin
         data_req_on = 1'b0;
         data_out    = 1'b1;
         if (data_wr) begin
            wr_busy   = 1'b1;
            aw_done   = 1'b0;
            w_done    = 1'b0;
            aw_addr_e = data_addr;
            aw_size_e = {1'b0, data_size};
            w_data_e  = data_wdata;
            w_strb_e  = data_wstrb;
            model_mem[{data_addr[31:2], 2'b00}] = merge(model_read(data_addr), data_wdata, data_wstrb);
            exp_data_q.push_back(32'h0);
            exp_data_rd_q.push_back(1'b0);
         end else begin
            rd_phase  = 1;
            rd_owner  = 1'b1;
            ar_addr_e = data_addr;
            ar_size_e = {1'b0, data_size};
            ar_id_e   = 4'd1;
            exp_data_q.push_back(model_read(data_addr));
            exp_data_rd_q.push_back(1'b1);
         end
      end
   endtask

   task automatic tick();
      cyc++;
      @(negedge clk);
      drive_inputs();
      #1;
      check_cycle();
   endtask

   task automatic clear_model();
      rd_phase = 0; wr_busy = 0; aw_done = 0; w_done = 0; r_delay = 0; b_delay = 0;
      inst_req_on = 0; inst_out = 0; data_req_on = 0; data_out = 0;
      exp_i_dok = 0; exp_d_dok = 0;
      last_inst_rdata = '0; last_data_rdata = '0;
      exp_inst_q.delete(); exp_data_q.delete(); exp_data_rd_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_arvalid"}, arvalid, 1'b0);
      check({tag, "_rready"}, rready, 1'b0);
      check({tag, "_awvalid"}, awvalid, 1'b0);
      check({tag, "_wvalid"}, wvalid, 1'b0);
      check({tag, "_bready"}, bready, 1'b0);
      check({tag, "_inst_data_ok"}, inst_data_ok, 1'b0);
      check({tag, "_data_data_ok"}, data_data_ok, 1'b0);
      check({tag, "_inst_addr_ok"}, inst_addr_ok, 1'b0);
      check({tag, "_data_addr_ok"}, data_addr_ok, 1'b0);
      check({tag, "_rd_state"}, rd_state, RD_IDLE);
      check({tag, "_wr_state"}, wr_state, WR_IDLE);
   endtask

   // Abandons an in-flight read: nothing may complete after reset asserts
   task automatic do_mid_reset();
      @(negedge clk);
      rst = 1'b0;
      inst_req = 0; data_req = 0; rvalid = 0; bvalid = 0;
      arready = 0; awready = 0; wready = 0;
      #1;
      check_idle_outputs("midrst");
      check("midrst_inst_rdata", inst_rdata, 32'h0);
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit busy;
      rst = 1'b0;
      inst_req = 0; inst_size = 0; inst_addr = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
      arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      clear_model();
      cyc = 0; first_acc_cyc = -1; first_lat_done = 0; did_reset = 0;
      zero_wait = 1'b1; gen_en = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      check_idle_outputs("rst");
      check("rst_araddr", araddr, 32'h0);
      check("rst_arid", arid, 4'h0);
      check("rst_awaddr", awaddr, 32'h0);
      check("rst_wdata", wdata, 32'h0);
      check("rst_data_rdata", data_rdata, 32'h0);
      check("arlen", arlen, 4'd0);
      check("awlen", awlen, 4'd0);
      check("arburst", arburst, 2'b01);
      check("awburst", awburst, 2'b01);
      check("axi_misc", {arlock, awlock, arcache, awcache, arprot, awprot}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // first fetch is the boot vector against a zero-wait slave
      inst_req_on = 1'b1;
      inst_addr   = 32'hBFC0_0000;
      inst_size   = 2'd2;

      for (int i = 0; i < 3000; i++) begin
         zero_wait = (i < 300) || (i >= 1200 && i < 1500);
         tick();
         if (i >= 1600 && !did_reset && rd_phase == 2) begin
            do_mid_reset();
            did_reset = 1'b1;
         end
      end
      check("mid_reset_seen", did_reset, 1'b1);
      check("first_latency_seen", first_lat_done, 1'b1);

      gen_en = 1'b0;
      busy   = 1'b1;
      for (int i = 0; i < 300 && busy; i++) begin
         tick();
         busy = inst_req_on || inst_out || data_req_on || data_out;
      end
      check("drained", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
Converts the core's two sram-like ports (instruction fetch and data access) into one AXI3 32-bit master. It sits directly downstream of mycpu_core's inst_sram/data_sram interfaces, inside the top-level wrapper. Each transfer is a single beat. Two independent engines run side by side: one read engine and one write engine. Instruction fetch may overlap an in-flight data write.

Parameters:
INST_ID, 4'd0, AXI arid used for instruction reads
DATA_ID, 4'd1, AXI arid/awid used for data accesses

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (rst=0 resets)
inst_req  in  1  instruction read request
inst_size  in  2  0=byte, 1=half, 2=word
inst_addr  in  32  byte address
inst_addr_ok  out  1  request accepted this cycle
inst_data_ok  out  1  rdata valid this cycle
inst_rdata  out  32  read data
data_req  in  1  data request
data_wr  in  1  1=write, 0=read
data_size  in  2  as inst_size
data_addr  in  32  byte address
data_wstrb  in  4  byte enables
data_wdata  in  32  write data
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  read data valid or write complete
data_rdata  out  32  read data
arid/araddr/arsize/arvalid  out  4/32/3/1  AR channel
arready  in  1  AR channel
rid/rdata/rvalid  in  4/32/1  R channel (rresp ignored)
rready  out  1  R channel
awid/awaddr/awsize/awvalid  out  4/32/3/1  AW channel
awready  in  1  AW channel
wdata/wstrb/wvalid  out  32/4/1  W channel; wlast is tied to 1
wready  in  1  W channel
bvalid  in  1  B channel
bready  out  1  B channel
arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  out  constant; len=0, burst=2'b01, all others 0

Behaviour:
- Reset (asynchronous, rst=0): both FSMs go to IDLE.
  - All valid, ready, addr_ok and data_ok outputs are 0.
  - All latched address, data and id registers are 0.
- Read FSM states: RD_IDLE -> RD_AR -> RD_R -> RD_IDLE.
  - RD_IDLE: the FSM accepts one read (priority rule below). Accepting raises the matching *_addr_ok combinationally for that cycle. On the accepting edge it latches addr, size, owner and id, then moves to RD_AR.
  - RD_AR: arvalid=1. araddr, arsize={1'b0,size} and arid stay stable until arready. On the arvalid&arready edge, move to RD_R.
  - RD_R: rready=1. On rvalid, pulse the owner's *_data_ok for exactly 1 cycle, driven as a registered output on the cycle after the rvalid edge. *_rdata holds the captured rdata until the next capture. Return to RD_IDLE on that same edge.
  - Minimum latency: request to data_ok is 3 cycles with a zero-wait slave.
- Write FSM states: WR_IDLE -> WR_REQ -> WR_B -> WR_IDLE.
  - WR_IDLE: accepts a data write, with data_addr_ok=1. Latches addr, size, wstrb and wdata.
  - WR_REQ: awvalid and wvalid are both raised. Each one drops independently after its own handshake, in either order or simultaneously. Move on once both handshakes are done.
  - WR_B: bready=1. On bvalid, pulse data_data_ok (registered, 1 cycle), then go to WR_IDLE.
- Acceptance and priority, evaluated combinationally each cycle:
  - A data read is accepted only when read FSM = RD_IDLE and write FSM = WR_IDLE. This guarantees read-after-write ordering.
  - A data write is accepted only when write FSM = WR_IDLE and the read FSM does not hold a data-owned read.
  - An inst read is accepted when read FSM = RD_IDLE and no data read is accepted in the same cycle. Data has priority.
  - Only one of inst_addr_ok and data_addr_ok may be 1 in any cycle.
- data_ok ordering: the core sees data_ok in the same order as addr_ok on each port, because each port has at most one outstanding transfer.
- Simultaneous completion: inst_data_ok from the read FSM and data_data_ok from the write FSM may both pulse in the same cycle.
- rid is not checked; the owner is the latched owner flag.
- Reset mid-transaction: all state is abandoned immediately and no data_ok is issued.

Decomposition:
- The shared defines header holds: FSM state encodings, AXI constants (LEN0, BURST_INCR, the ID values), and the size-to-arsize mapping.
- Sub-module: axi_wr_engine (write FSM plus AW/W/B channels). It is natural because it is independent of the read path. The read FSM stays in the top module.

Test Plan:
1. inst_req, inst_addr=0xBFC00000, zero-wait slave returns 0x3C1D0001 -> inst_addr_ok at cycle 0; arid=0, araddr=0xBFC00000, arsize=2; inst_data_ok=1 with inst_rdata=0x3C1D0001 exactly once.
2. inst_req and data read (addr 0x80001000) in the same cycle -> data_addr_ok=1, inst_addr_ok=0; data read completes first (arid=1); inst is accepted on the next RD_IDLE cycle.
3. Data write 0x80000010 (wstrb=4'b0011, wdata=0x1234ABCD), immediately followed by a data read of the same address -> read addr_ok held 0 until write data_ok; the AR for the read appears only after the bvalid handshake.
4. Write with wready given 3 cycles before awready -> wvalid drops after its handshake; awvalid stays high until awready; exactly one data_data_ok after bvalid.
5. Inst fetch issued while a write is in WR_B -> the inst AR goes out concurrently; both data_ok pulses arrive correctly, including in the same cycle.
6. rst driven to 0 during RD_R, then released -> all valids and readies are 0 immediately; no data_ok is issued; the next request is accepted normally.
